// File: rtl/bus_dma.sv
// bus_dma: single-channel memory-to-memory DMA controller.
//
// Copies COUNT words from SRC to DST as read-then-write pairs on the system
// bus. The bus request is dropped for one cycle between words so the CPU
// masters can win arbitration. A four-entry register file sits on the slave
// port. A level interrupt reports completion.
//
// Optional feature (macro BUS_DMA_ABORT_EN): CTRL bit4 ABORT stops the
// transfer after the word in flight completes. CTRL bit5 ERR flags the abort
// and is cleared by writing 1. Without the macro, both bits read 0 and
// ignore writes.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   s_cs_, s_as_, s_rw,        slave select/strobe (active-low), 1=read,
//   s_addr, s_wr_data          register index and write data
//   s_rd_data, s_rdy_          read data and ready, valid the cycle after access
//   m_req_, m_grnt_            bus request / grant (active-low)
//   m_addr, m_as_, m_rw,       master word address, strobe, 1=read
//   m_wr_data                  master write data
//   m_rd_data, m_rdy_          shared read data and ready (active-low)
//   irq                        DONE & IE, registered
//
// Register map (s_addr):
//   0 CTRL  bit0 START (w1, reads 0), bit1 BUSY (ro), bit2 DONE (w1c), bit3 IE
//   1 SRC   2 DST   3 COUNT

module bus_dma #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_cs_,
  input  logic              s_as_,
  input  logic              s_rw,
  input  logic [1:0]        s_addr,
  input  logic [DATA_W-1:0] s_wr_data,
  output logic [DATA_W-1:0] s_rd_data,
  output logic              s_rdy_,
  output logic              m_req_,
  input  logic              m_grnt_,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_as_,
  output logic              m_rw,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic [DATA_W-1:0] m_rd_data,
  input  logic              m_rdy_,
  output logic              irq
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD     = 3'd2,
    WR     = 3'd3,
    NEXT   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] src_r, dst_r;
  logic [CNT_W-1:0]  count_r;
  logic              done_r, ie_r, irq_r;
  logic              s_rdy_r;
  logic [DATA_W-1:0] s_rd_data_r;
  logic              m_req_r, m_as_r, m_rw_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_wr_data_r;

  logic              req_s, as_s, rw_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              step_s, done_set_s, abort_pend_s;
  logic              acc_s, wr_s, busy_s, ctrl_wr_s, start_s;
  logic [DATA_W-1:0] rd_val_s;
  logic              unused_s;

`ifdef BUS_DMA_ABORT_EN
  logic abort_r, err_r;
  assign abort_pend_s = abort_r;
`else
  assign abort_pend_s = 1'b0;
`endif

  assign acc_s     = ~s_cs_ & ~s_as_;
  assign wr_s      = acc_s & ~s_rw;
  assign busy_s    = (state_r != IDLE);
  assign ctrl_wr_s = wr_s & (s_addr == 2'd0);
  assign start_s   = ctrl_wr_s & s_wr_data[0] & ~busy_s;
  // Only the low bits of the write data land in registers.
  assign unused_s  = ^s_wr_data;

  // Register read mux; START always reads back as 0.
  always_comb begin
    rd_val_s = {DATA_W{1'b0}};
    case (s_addr)
      2'd0: begin
        rd_val_s[1] = busy_s;
        rd_val_s[2] = done_r;
        rd_val_s[3] = ie_r;
`ifdef BUS_DMA_ABORT_EN
        rd_val_s[5] = err_r;
`endif
      end
      2'd1:    rd_val_s = DATA_W'(src_r);
      2'd2:    rd_val_s = DATA_W'(dst_r);
      2'd3:    rd_val_s = DATA_W'(count_r);
      default: rd_val_s = {DATA_W{1'b0}};
    endcase
  end

  // Next state and next registered bus outputs.
  always_comb begin
    state_s    = state_r;
    req_s      = m_req_r;
    as_s       = 1'b1;
    rw_s       = m_rw_r;
    addr_s     = m_addr_r;
    wdata_s    = m_wr_data_r;
    step_s     = 1'b0;
    done_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s && (count_r != CNT_ZERO)) begin
          state_s = RD_REQ;
          req_s   = 1'b0;
        end else if (start_s) begin
          // Empty transfer: report completion without touching the bus.
          done_set_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RD_REQ: begin
        req_s = 1'b0;
        if (!m_grnt_) begin
          as_s    = 1'b0;
          rw_s    = 1'b1;
          addr_s  = src_r;
          state_s = RD;
        end else begin
          state_s = RD_REQ;
        end
      end
      RD: begin
        // Grant is not rechecked here: the arbiter never revokes mid-pair.
        if (!m_rdy_) begin
          wdata_s = m_rd_data;
          as_s    = 1'b0;
          rw_s    = 1'b0;
          addr_s  = dst_r;
          state_s = WR;
        end else begin
          state_s = RD;
        end
      end
      WR: begin
        if (!m_rdy_) begin
          step_s  = 1'b1;
          req_s   = 1'b1;
          rw_s    = 1'b1;
          state_s = NEXT;
        end else begin
          state_s = WR;
        end
      end
      NEXT: begin
        // COUNT has already been decremented for the word just written.
        if ((count_r == CNT_ZERO) || abort_pend_s) begin
          state_s    = IDLE;
          done_set_s = 1'b1;
        end else begin
          state_s = RD_REQ;
          req_s   = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b1;
        rw_s    = 1'b1;
      end
    endcase
  end

  // FSM state and registered master-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      m_req_r     <= 1'b1;
      m_as_r      <= 1'b1;
      m_rw_r      <= 1'b1;
      m_addr_r    <= {ADDR_W{1'b0}};
      m_wr_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      m_req_r     <= req_s;
      m_as_r      <= as_s;
      m_rw_r      <= rw_s;
      m_addr_r    <= addr_s;
      m_wr_data_r <= wdata_s;
    end
  end

  // SRC/DST/COUNT: software writes only while idle, hardware advances per word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_r   <= {ADDR_W{1'b0}};
      dst_r   <= {ADDR_W{1'b0}};
      count_r <= CNT_ZERO;
    end else if (step_s) begin
      src_r   <= src_r + ADDR_ONE;
      dst_r   <= dst_r + ADDR_ONE;
      count_r <= count_r - CNT_ONE;
    end else if (wr_s && !busy_s) begin
      if (s_addr == 2'd1) begin
        src_r <= s_wr_data[ADDR_W-1:0];
      end else if (s_addr == 2'd2) begin
        dst_r <= s_wr_data[ADDR_W-1:0];
      end else if (s_addr == 2'd3) begin
        count_r <= s_wr_data[CNT_W-1:0];
      end else begin
        src_r <= src_r;
      end
    end else begin
      count_r <= count_r;
    end
  end

  // CTRL flags; a hardware DONE set beats a coincident write-1-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_r <= 1'b0;
      ie_r   <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      irq_r <= done_r & ie_r;
      if (ctrl_wr_s) begin
        ie_r <= s_wr_data[3];
      end else begin
        ie_r <= ie_r;
      end
      if (done_set_s) begin
        done_r <= 1'b1;
      end else if (ctrl_wr_s && s_wr_data[2]) begin
        done_r <= 1'b0;
      end else begin
        done_r <= done_r;
      end
    end
  end

`ifdef BUS_DMA_ABORT_EN
  // Abort request is held until the current word finishes in NEXT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      abort_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if ((state_r == NEXT) && abort_r) begin
        abort_r <= 1'b0;
      end else if (ctrl_wr_s && s_wr_data[4] && busy_s) begin
        abort_r <= 1'b1;
      end else begin
        abort_r <= abort_r;
      end
      if ((state_r == NEXT) && abort_r) begin
        err_r <= 1'b1;
      end else if (ctrl_wr_s && s_wr_data[5]) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end
`endif

  // Slave response: ready and read data for exactly one cycle after an access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_rdy_r     <= 1'b1;
      s_rd_data_r <= {DATA_W{1'b0}};
    end else begin
      s_rdy_r <= ~acc_s;
      if (acc_s && s_rw) begin
        s_rd_data_r <= rd_val_s;
      end else begin
        s_rd_data_r <= {DATA_W{1'b0}};
      end
    end
  end

  assign s_rd_data = s_rd_data_r;
  assign s_rdy_    = s_rdy_r;
  assign m_req_    = m_req_r;
  assign m_as_     = m_as_r;
  assign m_rw      = m_rw_r;
  assign m_addr    = m_addr_r;
  assign m_wr_data = m_wr_data_r;
  assign irq       = irq_r;

endmodule

// File: tb/tb_bus_dma.sv
// Directed testbench for bus_dma: register access, multi-word copies against
// a bus memory/arbiter model, empty transfer, grant/ready delays, address
// wrap, optional abort (BUS_DMA_ABORT_EN) and asynchronous reset mid-write.
module tb_bus_dma;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              s_cs_ = 1'b1;
  logic              s_as_ = 1'b1;
  logic              s_rw = 1'b1;
  logic [1:0]        s_addr = 2'd0;
  logic [DATA_W-1:0] s_wr_data = 32'h0;
  logic [DATA_W-1:0] s_rd_data;
  logic              s_rdy_;
  logic              m_req_;
  logic              m_grnt_ = 1'b1;
  logic [ADDR_W-1:0] m_addr;
  logic              m_as_;
  logic              m_rw;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] m_rd_data = 32'h0;
  logic              m_rdy_ = 1'b1;
  logic              irq;

  always #5 clk = ~clk;

  bus_dma #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .s_cs_(s_cs_), .s_as_(s_as_), .s_rw(s_rw), .s_addr(s_addr),
    .s_wr_data(s_wr_data), .s_rd_data(s_rd_data), .s_rdy_(s_rdy_),
    .m_req_(m_req_), .m_grnt_(m_grnt_), .m_addr(m_addr), .m_as_(m_as_),
    .m_rw(m_rw), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
    .m_rdy_(m_rdy_), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [29:0] a);
    return {2'b00, a} ^ 32'h5A5A_0000;
  endfunction

  // Bus memory + arbiter model
  int lat = 1;
  int gdelay = 0;
  int pend = 0;
  int req_run = 0;
  int hi_run = 0;
  int req_lo_cnt = 0;
  bit seen_low = 1'b0;
  logic prev_as_lo = 1'b0;
  logic [29:0] cur_addr = 30'h0;
  logic cur_rw = 1'b1;
  logic [29:0] log_addr[$];
  logic        log_rw[$];
  logic [31:0] log_data[$];
  int          gaps[$];

  always @(negedge clk) begin
    m_rdy_ = 1'b1;
    m_rd_data = 32'h0;
    if (!reset) begin
      pend = 0;
      req_run = 0;
      m_grnt_ = 1'b1;
      prev_as_lo = 1'b0;
    end else begin
      if (pend > 0) begin
        chk("m_addr_hold", m_addr, cur_addr);
        chk("m_rw_hold", m_rw, cur_rw);
        chk("m_as_idle", m_as_, 1'b1);
        pend--;
        if (pend == 0) begin
          m_rdy_ = 1'b0;
          if (cur_rw) m_rd_data = mem_val(cur_addr);
        end
      end
      if (!m_as_) begin
        chk("m_as_single", prev_as_lo, 1'b0);
        cur_addr = m_addr;
        cur_rw = m_rw;
        pend = lat;
        log_addr.push_back(m_addr);
        log_rw.push_back(m_rw);
        log_data.push_back(m_rw ? mem_val(m_addr) : m_wr_data);
      end
      prev_as_lo = !m_as_;
      if (!m_req_) begin
        req_run++;
        req_lo_cnt++;
        m_grnt_ = (req_run > gdelay) ? 1'b0 : 1'b1;
        if (seen_low && hi_run > 0) gaps.push_back(hi_run);
        hi_run = 0;
        seen_low = 1'b1;
      end else begin
        req_run = 0;
        m_grnt_ = 1'b1;
        hi_run++;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_rw.delete();
    log_data.delete();
    gaps.delete();
    seen_low = 1'b0;
    hi_run = 0;
  endtask

  // Called at a negedge; returns at the next negedge with the response.
  task automatic reg_acc(input logic rw, input logic [1:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic rdy);
    s_cs_ = 1'b0; s_as_ = 1'b0; s_rw = rw; s_addr = a; s_wr_data = wd;
    @(negedge clk);
    rd = s_rd_data;
    rdy = s_rdy_;
    s_cs_ = 1'b1; s_as_ = 1'b1; s_rw = 1'b1; s_wr_data = 32'h0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic y;
    reg_acc(1'b0, a, d, r, y);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    logic y;
    reg_acc(1'b1, a, 32'h0, d, y);
  endtask

  task automatic wait_idle(input string tag, output logic [31:0] ctrl);
    logic [31:0] c;
    logic busy;
    busy = 1'b1;
    c = 32'h0;
    for (int i = 0; i < 2000 && busy; i++) begin
      rd(2'd0, c);
      busy = c[1];
    end
    chk(tag, busy, 1'b0);
    ctrl = c;
  endtask

  task automatic chk_copy(input string tag, input logic [29:0] src, input logic [29:0] dst, input int n);
    logic [29:0] ea;
    chk({tag, "_n"}, log_addr.size(), 2 * n);
    if (log_addr.size() == 2 * n) begin
      for (int i = 0; i < n; i++) begin
        ea = src + 30'(i);
        chk({tag, "_rd"}, {log_rw[2*i], log_addr[2*i]}, {1'b1, ea});
        chk({tag, "_wd"}, log_data[2*i+1], mem_val(ea));
        ea = dst + 30'(i);
        chk({tag, "_wr"}, {log_rw[2*i+1], log_addr[2*i+1]}, {1'b0, ea});
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic y;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_slave", {s_rdy_, s_rd_data}, {1'b1, 32'h0});
    chk("rst_master", {m_req_, m_as_, m_rw, m_addr}, {3'b111, 30'h0});
    chk("rst_wd_irq", {m_wr_data, irq}, 33'h0);
    reset = 1'b1;
    @(negedge clk);
    rd(2'd0, v); chk("rst_ctrl", v, 32'h0);
    rd(2'd3, v); chk("rst_count", v, 32'h0);

    // Register read/write and single-cycle ready
    wr(2'd1, 32'h100);
    wr(2'd2, 32'h200);
    reg_acc(1'b0, 2'd3, 32'h4, v, y);
    chk("wr_rdy", y, 1'b0);
    @(negedge clk);
    chk("wr_rdy_end", s_rdy_, 1'b1);
    reg_acc(1'b1, 2'd1, 32'h0, v, y);
    chk("src_rb", v, 32'h100);
    chk("rd_rdy", y, 1'b0);
    @(negedge clk);
    chk("rd_rdy_end", {s_rdy_, s_rd_data}, {1'b1, 32'h0});
    rd(2'd2, v); chk("dst_rb", v, 32'h200);
    rd(2'd3, v); chk("count_rb", v, 32'h4);
    wr(2'd0, 32'h30);
    rd(2'd0, v); chk("ctrl_b45_idle", v, 32'h0);

    // 4-word copy, immediate grant, 1-cycle slave
    lat = 1; gdelay = 0; clear_log();
    wr(2'd0, 32'h9);
    wait_idle("copy4_timeout", v);
    chk("copy4_ctrl", v, 32'hC);
    chk_copy("copy4", 30'h100, 30'h200, 4);
    chk("copy4_gaps", gaps.size(), 3);
    foreach (gaps[k]) chk("copy4_gap_len", gaps[k], 1);
    rd(2'd3, v); chk("copy4_count", v, 32'h0);
    rd(2'd1, v); chk("copy4_src", v, 32'h104);
    rd(2'd2, v); chk("copy4_dst", v, 32'h204);
    chk("copy4_irq", irq, 1'b1);

    // COUNT=0 start: DONE next cycle, no bus request, irq off with IE=0
    wr(2'd0, 32'h4);
    repeat (2) @(negedge clk);
    chk("irq_clr", irq, 1'b0);
    req_lo_cnt = 0;
    wr(2'd0, 32'h1);
    rd(2'd0, v); chk("cnt0_done", v, 32'h4);
    repeat (4) @(negedge clk);
    chk("cnt0_noreq", req_lo_cnt, 0);
    chk("cnt0_irq", irq, 1'b0);

    // Grant held off 10 cycles, slave ready after 3 cycles
    wr(2'd0, 32'h4);
    lat = 3; gdelay = 10; clear_log();
    wr(2'd1, 32'h40); wr(2'd2, 32'h80); wr(2'd3, 32'h2); wr(2'd0, 32'h1);
    wait_idle("gd_timeout", v);
    chk("gd_ctrl", v, 32'h4);
    chk_copy("gd", 30'h40, 30'h80, 2);

    // Address wrap; START and COUNT writes while busy are ignored
    wr(2'd0, 32'h4);
    lat = 1; gdelay = 0; clear_log();
    wr(2'd1, 32'h3FFF_FFFF); wr(2'd2, 32'h300); wr(2'd3, 32'h2);
    wr(2'd0, 32'h1); wr(2'd0, 32'h1); wr(2'd3, 32'h9);
    wait_idle("wrap_timeout", v);
    chk("wrap_ctrl", v, 32'h4);
    chk_copy("wrap", 30'h3FFF_FFFF, 30'h300, 2);
    rd(2'd1, v); chk("wrap_src", v, 32'h1);
    rd(2'd3, v); chk("wrap_count", v, 32'h0);

`ifdef BUS_DMA_ABORT_EN
    // Abort while the third word's read is pending
    wr(2'd0, 32'h4);
    lat = 3; gdelay = 0; clear_log();
    wr(2'd1, 32'h500); wr(2'd2, 32'h600); wr(2'd3, 32'h8); wr(2'd0, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = (log_addr.size() >= 5);
    end
    chk("ab_wait", seen, 1'b1);
    wr(2'd0, 32'h10);
    wait_idle("ab_timeout", v);
    chk("ab_ctrl", v, 32'h24);
    chk_copy("ab", 30'h500, 30'h600, 3);
    rd(2'd3, v); chk("ab_count", v, 32'h5);
    wr(2'd0, 32'h20);
    rd(2'd0, v); chk("ab_err_clr", v, 32'h4);
`endif

    // Asynchronous reset during a write access
    wr(2'd0, 32'h4);
    lat = 6; gdelay = 0; clear_log();
    wr(2'd1, 32'h700); wr(2'd2, 32'h7F0); wr(2'd3, 32'h3); wr(2'd0, 32'h9);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = (log_addr.size() >= 2);
    end
    chk("mw_wait", seen, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mw_rst_master", {m_req_, m_as_, m_rw, m_addr}, {3'b111, 30'h0});
    chk("mw_rst_wd_irq", {m_wr_data, irq}, 33'h0);
    chk("mw_rst_slave", {s_rdy_, s_rd_data}, {1'b1, 32'h0});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rd(2'd0, v); chk("mw_ctrl", v, 32'h0);
    rd(2'd3, v); chk("mw_count", v, 32'h0);
    rd(2'd1, v); chk("mw_src", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_dma.md
Name: bus_dma

Overview:
- Single-channel memory-to-memory DMA controller.
- Occupies bus master 2 (word-granular read-then-write transfers) and bus slave 5 (4-word register file), with an interrupt line to the CPU IRQ vector.
- Copies COUNT words from SRC to DST without CPU involvement.
- Releases the bus between words so the CPU masters (0/1) are not starved.

Parameters:
- CNT_W, 16, width of the COUNT register (maximum transfer of 2^CNT_W-1 words).
- ADDR_W, 30, word-address width on the master side.
- DATA_W, 32, bus data width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- s_cs_  in  1  slave chip select, active-low
- s_as_  in  1  slave address strobe, active-low
- s_rw  in  1  1=read, 0=write
- s_addr  in  2  register index
- s_wr_data  in  DATA_W  register write data
- s_rd_data  out  DATA_W  register read data
- s_rdy_  out  1  slave ready, active-low
- m_req_  out  1  bus request, active-low
- m_grnt_  in  1  bus grant, active-low
- m_addr  out  ADDR_W  master word address
- m_as_  out  1  master address strobe, active-low
- m_rw  out  1  1=read, 0=write
- m_wr_data  out  DATA_W  master write data
- m_rd_data  in  DATA_W  shared read data
- m_rdy_  in  1  shared ready, active-low
- irq  out  1  completion interrupt, active-high level

Behaviour:
- Registers, selected by s_addr:
  - 0 CTRL: bit0 START (write 1, self-clearing, reads 0); bit1 BUSY (read-only); bit2 DONE (write 1 clears); bit3 IE.
  - 1 SRC.
  - 2 DST.
  - 3 COUNT.
- Slave access: when s_cs_ and s_as_ are both low in a cycle, the access is performed. s_rdy_ and s_rd_data are driven for exactly the following cycle; otherwise s_rdy_=1 and s_rd_data=0.
- Reset values:
  - All registers 0; s_rdy_=1, s_rd_data=0.
  - m_req_=1, m_as_=1, m_rw=1, m_addr=0, m_wr_data=0, irq=0.
  - FSM in IDLE.
- While BUSY, writes to SRC, DST, COUNT and START are ignored. Writes to DONE and IE are still accepted.
- START with COUNT=0: DONE set the next cycle; no bus activity.
- FSM states: IDLE, RD_REQ, RD, WR, NEXT.
  - IDLE -> RD_REQ on accepted START with COUNT≠0. BUSY=1.
  - RD_REQ: m_req_=0. When m_grnt_=0, drive m_as_=0, m_rw=1, m_addr=SRC for one cycle, then go to RD.
  - RD: keep m_req_=0 and addr/rw stable, m_as_=1. On m_rdy_=0, latch m_rd_data into m_wr_data. The next cycle drives m_as_=0, m_rw=0, m_addr=DST; go to WR.
  - WR: on m_rdy_=0, SRC+=1 and DST+=1 (modulo 2^ADDR_W, wrap), COUNT-=1; go to NEXT.
  - NEXT: m_req_=1 for exactly one cycle. If COUNT=0, go to IDLE with BUSY=0 and DONE=1; else go to RD_REQ.
- m_req_ stays low from grant through the write of each word, so a read/write pair is atomic.
- Loss of grant (m_grnt_=1) during RD or WR does not occur in the system arbiter protocol. The FSM ignores m_grnt_ once in RD or WR.
- irq = DONE & IE, registered.
- A DONE write-1-clear coinciding with a hardware DONE set: the set wins.
- Mid-operation reset: FSM returns to IDLE and all outputs take reset values immediately (asynchronous).
- SRC, DST and COUNT read back live (current) values during a transfer.

Optional Feature:
- Macro: BUS_DMA_ABORT_EN.
- Enabled:
  - CTRL bit4 ABORT (write 1 while BUSY).
  - The FSM completes the current word (a pending read/write pair is never split), then enters IDLE with DONE=1 and CTRL bit5 ERR=1. ERR is write-1-clear.
  - ABORT in IDLE is ignored.
- Disabled: bits 4 and 5 read 0 and writes to them have no effect.

Test Plan:
- Register R/W: write SRC=0x100, DST=0x200, COUNT=4, read each back -> values match; s_rdy_ low exactly 1 cycle after each access.
- 4-word copy with immediate grant and 1-cycle slave latency:
  - 4 reads at 0x100..0x103 and 4 writes at 0x200..0x203 with matching data.
  - m_req_ high 1 cycle between words.
  - DONE=1, COUNT=0, irq=1 with IE=1.
- COUNT=0 START -> no m_req_ assertion; DONE=1 the next cycle; irq stays 0 with IE=0.
- Grant held off 10 cycles, slave rdy_ delayed 3 cycles -> m_as_ pulses exactly once per access; address/rw stable until m_rdy_ low; data correct.
- Wrap: SRC=0x3FFFFFFF, COUNT=2 -> second read at 0x00000000; START written while BUSY is ignored.
- With BUS_DMA_ABORT_EN, COUNT=8, ABORT after word 2 read issued -> word 2 write completes; COUNT=5; DONE=1, ERR=1. Assert reset mid-write -> all outputs at reset values immediately.
